top: RTL and testbench
======================

TOP -- requirements
Module: top

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 18_000_000, meaning CLK_IN frequency in Hz.
REQ-002 SHALL have parameter BAUDRATE, default 115_200, meaning UART bit rate in bits/s.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, meaning number of 8-bit SRAM words (power of two).
REQ-004 SHALL have port CLK_IN  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port RST_N_IN  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port UART_RX_i  input  1  asynchronous serial input, idle high, 8N1.
REQ-007 SHALL have port LED_o  output  8  last byte read back from SRAM.
REQ-008 SHALL have port WR_ADDR_o  output  log2(MEM_DEPTH)  next SRAM write address.
REQ-009 SHALL have port BYTE_VALID_o  output  1  one-cycle pulse when LED_o updates.
REQ-010 SHALL have port ERR_o  output  1  sticky error flag: framing error or readback mismatch.

Function
REQ-011 SHALL compute BIT_TICKS = CLK_FREQ/BAUDRATE (integer division; 156 at defaults) and HALF_TICKS = BIT_TICKS/2.
REQ-012 SHALL pass UART_RX_i through a two-flop synchronizer (reset value 1) before any use.
REQ-013 SHALL run receiver FSM with states IDLE, START, DATA, STOP.
REQ-014 IDLE: on synchronized RX = 0, SHALL go to START and clear tick counter.
REQ-015 START: after HALF_TICKS, if RX = 0 SHALL go to DATA; if RX = 1 (glitch) SHALL return to IDLE with no error.
REQ-016 DATA: SHALL sample RX every BIT_TICKS, 8 samples, LSB first, then go to STOP.
REQ-017 STOP: after BIT_TICKS, if RX = 1 SHALL assert internal rx_valid for one cycle with the byte; if RX = 0 SHALL set ERR_o, discard the byte; both SHALL return to IDLE.
REQ-018 A new start bit SHALL be accepted in IDLE on the cycle after STOP completes (back-to-back bytes supported).
REQ-019 On rx_valid, SHALL write the byte to SRAM[wr_addr] in the same cycle and hold its address for readback.
REQ-020 One cycle after the write, SHALL read SRAM at that address (synchronous read, 1-cycle latency).
REQ-021 Two cycles after rx_valid, SHALL load readback into LED_o and pulse BYTE_VALID_o for exactly one cycle.
REQ-022 If readback differs from the written byte, SHALL set ERR_o.
REQ-023 SHALL increment wr_addr by 1 after each write, wrapping from MEM_DEPTH-1 to 0.
REQ-024 ERR_o SHALL remain set until reset.
REQ-025 A write and a readback pipeline SHALL never collide: minimum byte spacing (10 bit times) exceeds the 2-cycle pipeline.

Reset
REQ-026 On RST_N_IN = 0, SHALL immediately force FSM = IDLE, counters = 0, LED_o = 0x00, WR_ADDR_o = 0, BYTE_VALID_o = 0, ERR_o = 0, synchronizer = 1.
REQ-027 SRAM contents SHALL NOT be reset.
REQ-028 Reset mid-byte SHALL abort the byte; no write occurs; reception resumes on the next start bit after release.

Structure
REQ-029 SHALL place BIT_TICKS/HALF_TICKS derivation and FSM state encoding in a shared package.
REQ-030 SHALL implement the receiver as sub-module uart_rx (outputs data[7:0], valid, frame_err); SRAM, address counter and readback stay in top.
REQ-031 SRAM SHALL be inferable as single-port block RAM (no reset, synchronous read).

Verification
REQ-032 Reset, then send 0x55 at BAUDRATE -> ~2 cycles after stop-bit sample: LED_o = 0x55, BYTE_VALID_o one pulse, WR_ADDR_o = 1, ERR_o = 0.
REQ-033 Send 0xA5, 0x00, 0xFF back-to-back -> LED_o sequence A5, 00, FF; WR_ADDR_o = 3; SRAM[0..2] = A5,00,FF.
REQ-034 Send 0x3C with stop bit = 0 -> no BYTE_VALID_o, WR_ADDR_o unchanged, ERR_o = 1.
REQ-035 Low pulse on UART_RX_i of HALF_TICKS/2 cycles -> no byte, no error, FSM back in IDLE.
REQ-036 Assert RST_N_IN during bit 4 of a byte -> outputs at reset values immediately; next full byte 0x12 received correctly at address 0.
REQ-037 Send MEM_DEPTH+1 bytes -> WR_ADDR_o wraps to 0 then 1; SRAM[0] holds the last byte.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART-to-SRAM loopback: receiver state encoding and baud timing helpers.
package uart_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } rx_state_t;

    function automatic int unsigned bit_ticks(input int unsigned clk_freq, input int unsigned baud);
        return clk_freq / baud;
    endfunction

    function automatic int unsigned half_ticks(input int unsigned clk_freq, input int unsigned baud);
        return bit_ticks(clk_freq, baud) / 2;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes RX, centres on the start bit, then samples once per bit time.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 18_000_000,
    parameter int unsigned BAUDRATE = 115_200
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_frame_err
);

    localparam int unsigned BIT_TICKS  = bit_ticks(CLK_FREQ, BAUDRATE);
    localparam int unsigned HALF_TICKS = half_ticks(CLK_FREQ, BAUDRATE);
    localparam int          CNT_W      = $clog2(BIT_TICKS + 1);

    logic [1:0]       r_sync;
    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             w_rx;
    logic             w_half_done;
    logic             w_bit_done;
    logic             w_cnt_clr;

    assign w_rx        = r_sync[1];
    assign w_half_done = (r_cnt == CNT_W'(HALF_TICKS - 1));
    assign w_bit_done  = (r_cnt == CNT_W'(BIT_TICKS - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sync <= 2'b11;
        else          r_sync <= {r_sync[0], i_rx};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (!w_rx) w_state_nxt = S_START;
            S_START: if (w_half_done) w_state_nxt = w_rx ? S_IDLE : S_DATA;
            S_DATA:  if (w_bit_done && r_bit_idx == 3'd7) w_state_nxt = S_STOP;
            S_STOP:  if (w_bit_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Counter restarts on every state change and at each data-bit boundary.
    assign w_cnt_clr = (r_state == S_IDLE) || (w_state_nxt != r_state) ||
                       (r_state == S_DATA && w_bit_done);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_cnt <= w_cnt_clr ? '0 : r_cnt + 1'b1;
            if (r_state == S_IDLE) r_bit_idx <= '0;
            if (r_state == S_DATA && w_bit_done) begin
                r_shift   <= {w_rx, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 1'b1;
            end
        end
    end

    always_comb begin
        o_data      = r_shift;
        o_valid     = 1'b0;
        o_frame_err = 1'b0;
        if (r_state == S_STOP && w_bit_done) begin
            o_valid     = w_rx;
            o_frame_err = !w_rx;
        end
    end

endmodule

// File: rtl/top.sv
// UART byte capture into single-port SRAM with readback verify; the read-back byte drives the LEDs.
module top
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 18_000_000,
    parameter int unsigned BAUDRATE  = 115_200,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic                         CLK_IN,
    input  logic                         RST_N_IN,
    input  logic                         UART_RX_i,
    output logic [7:0]                   LED_o,
    output logic [$clog2(MEM_DEPTH)-1:0] WR_ADDR_o,
    output logic                         BYTE_VALID_o,
    output logic                         ERR_o
);

    localparam int AW = $clog2(MEM_DEPTH);

    logic [7:0]    w_rx_data;
    logic          w_rx_valid;
    logic          w_frame_err;
    logic [AW-1:0] w_ram_addr;

    logic [7:0]    r_mem [MEM_DEPTH];
    logic [7:0]    r_rd_data;
    logic [AW-1:0] r_wr_addr;
    logic [AW-1:0] r_rd_addr;
    logic [7:0]    r_wr_byte;
    logic [1:0]    r_vld_pipe;
    logic [7:0]    r_led;
    logic          r_byte_vld;
    logic          r_err;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUDRATE (BAUDRATE)
    ) u_rx (
        .i_clk       (CLK_IN),
        .i_rst_n     (RST_N_IN),
        .i_rx        (UART_RX_i),
        .o_data      (w_rx_data),
        .o_valid     (w_rx_valid),
        .o_frame_err (w_frame_err)
    );

    // One shared port: bytes are at least 10 bit times apart, so write and readback never overlap.
    assign w_ram_addr = w_rx_valid ? r_wr_addr : r_rd_addr;

    always_ff @(posedge CLK_IN) begin
        if (w_rx_valid)         r_mem[w_ram_addr] <= w_rx_data;
        else if (r_vld_pipe[0]) r_rd_data <= r_mem[w_ram_addr];
    end

    always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            r_wr_addr  <= '0;
            r_rd_addr  <= '0;
            r_wr_byte  <= '0;
            r_vld_pipe <= '0;
            r_led      <= '0;
            r_byte_vld <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0], w_rx_valid};
            r_byte_vld <= r_vld_pipe[1];
            if (w_rx_valid) begin
                r_rd_addr <= r_wr_addr;
                r_wr_byte <= w_rx_data;
                r_wr_addr <= r_wr_addr + 1'b1;
            end
            if (r_vld_pipe[1]) r_led <= r_rd_data;
            if (w_frame_err || (r_vld_pipe[1] && r_rd_data != r_wr_byte)) r_err <= 1'b1;
        end
    end

    assign LED_o        = r_led;
    assign WR_ADDR_o    = r_wr_addr;
    assign BYTE_VALID_o = r_byte_vld;
    assign ERR_o        = r_err;

endmodule

// File: tb/tb_top.sv
// Directed bench for the UART-to-SRAM loopback, run at 16 clocks per bit and a 16-word SRAM.
module tb_top;

    localparam int unsigned CF = 1_600_000;
    localparam int unsigned BR = 100_000;
    localparam int unsigned MD = 16;
    localparam int          BT = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] led;
    logic [3:0] wr_addr;
    logic       bv;
    logic       err;

    int         n_chk = 0;
    int         n_bad = 0;
    int         n_pulse = 0;
    int         p0;
    logic [7:0] seen [$];
    logic [7:0] b;

    top #(.CLK_FREQ(CF), .BAUDRATE(BR), .MEM_DEPTH(MD)) dut (
        .CLK_IN       (clk),
        .RST_N_IN     (rst_n),
        .UART_RX_i    (rx),
        .LED_o        (led),
        .WR_ADDR_o    (wr_addr),
        .BYTE_VALID_o (bv),
        .ERR_o        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bv) begin
            n_pulse <= n_pulse + 1;
            seen.push_back(led);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_bits(input int n);
        repeat (n * BT) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_bits(1);
        end
        rx = stop;
        wait_bits(1);
        rx = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_led", led, 8'h00);
        chk("rst_addr", wr_addr, 4'd0);
        chk("rst_bv", bv, 1'b0);
        chk("rst_err", err, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // single byte
        send(8'h55, 1'b1);
        repeat (4) @(negedge clk);
        chk("b55_led", led, 8'h55);
        chk("b55_pulses", n_pulse, 1);
        chk("b55_addr", wr_addr, 4'd1);
        chk("b55_err", err, 1'b0);

        // back-to-back bytes
        do_reset();
        seen.delete();
        send(8'hA5, 1'b1);
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        repeat (4) @(negedge clk);
        chk("b2b_cnt", seen.size(), 3);
        chk("b2b_led0", seen[0], 8'hA5);
        chk("b2b_led1", seen[1], 8'h00);
        chk("b2b_led2", seen[2], 8'hFF);
        chk("b2b_addr", wr_addr, 4'd3);
        chk("b2b_mem0", dut.r_mem[0], 8'hA5);
        chk("b2b_mem1", dut.r_mem[1], 8'h00);
        chk("b2b_mem2", dut.r_mem[2], 8'hFF);

        // framing error
        p0 = n_pulse;
        send(8'h3C, 1'b0);
        wait_bits(1);
        chk("ferr_pulses", n_pulse, p0);
        chk("ferr_addr", wr_addr, 4'd3);
        chk("ferr_err", err, 1'b1);
        chk("ferr_led", led, 8'hFF);

        // start-bit glitch
        do_reset();
        chk("err_cleared", err, 1'b0);
        p0 = n_pulse;
        rx = 1'b0;
        repeat (BT / 4) @(negedge clk);
        rx = 1'b1;
        wait_bits(3);
        chk("glitch_pulses", n_pulse, p0);
        chk("glitch_err", err, 1'b0);
        chk("glitch_addr", wr_addr, 4'd0);
        chk("glitch_idle", 32'(dut.u_rx.r_state), 32'd0);

        // reset during bit 4
        send(8'h77, 1'b1);
        repeat (4) @(negedge clk);
        chk("pre_led", led, 8'h77);
        chk("pre_addr", wr_addr, 4'd1);
        b = 8'hE9;
        rx = 1'b0;
        wait_bits(1);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            wait_bits(1);
        end
        rx = b[4];
        repeat (BT / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_led", led, 8'h00);
        chk("mid_addr", wr_addr, 4'd0);
        chk("mid_bv", bv, 1'b0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        wait_bits(1);
        send(8'h12, 1'b1);
        repeat (4) @(negedge clk);
        chk("post_led", led, 8'h12);
        chk("post_addr", wr_addr, 4'd1);
        chk("post_mem0", dut.r_mem[0], 8'h12);
        chk("post_err", err, 1'b0);

        // address wrap over MD+1 bytes, byte i = i*13+1
        do_reset();
        for (int i = 0; i < 16; i++) send(8'(i * 13 + 1), 1'b1);
        repeat (4) @(negedge clk);
        chk("wrap_addr0", wr_addr, 4'd0);
        chk("wrap_led15", led, 8'hC4);
        send(8'hD1, 1'b1);
        repeat (4) @(negedge clk);
        chk("wrap_addr1", wr_addr, 4'd1);
        chk("wrap_mem0", dut.r_mem[0], 8'hD1);
        chk("wrap_mem1", dut.r_mem[1], 8'h0E);
        chk("wrap_led", led, 8'hD1);
        chk("wrap_err", err, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
